// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM and MEM/WB pipeline registers plus the data-memory
// req/ack sequencer. It produces the MEM and WB forwarding sources for the EX
// stage and the stall that freezes IF, ID and EX while an access is pending.
// Optional build macro: MEM_PERF_CNT_EN adds the stall_cycles and mem_ops
// performance counters. When it is undefined, neither the ports nor the
// counter logic exist.
module mem_wb_stage #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TCNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        MemRead_mem,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        bus_err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] mem_ops
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

  // Last WAIT cycle before giving up: after ACK_TIMEOUT wait cycles the access aborts.
  localparam logic [TCNT_W-1:0] TimeoutLast = TCNT_W'(ACK_TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] CntMax      = {TCNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;

  // EX/MEM pipeline register
  logic        valid_mem_q;
  logic [31:0] alu_mem_q;
  logic [31:0] wdata_mem_q;
  logic [4:0]  rd_mem_q;
  logic        regwrite_mem_q;
  logic        memread_mem_q;
  logic        memwrite_mem_q;
  logic        memtoreg_mem_q;

  // MEM/WB pipeline register
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q;
  logic        wb_we_q, wb_we_d;

  logic        bus_err_q;
  logic        memop;
  logic        in_abort;

  assign memop    = valid_mem_q & (memread_mem_q | memwrite_mem_q);
  assign in_abort = (state_q == StAbort);

  // Memory interface, stall and forwarding outputs. Address, direction and
  // store data come straight from EX/MEM, which is frozen while stalled, so
  // they stay stable from request to ack.
  always_comb begin
    dmem_req        = memop & ~in_abort;
    dmem_we         = valid_mem_q & memwrite_mem_q;
    dmem_addr       = alu_mem_q;
    dmem_wdata      = wdata_mem_q;
    stall_mem       = memop & ~dmem_ack & ~in_abort;
    MemRead_mem     = valid_mem_q & memread_mem_q;
    ALUResult_mem   = alu_mem_q;
    rdAddr_mem      = rd_mem_q;
    RegWrite_mem    = regwrite_mem_q;
    RegWriteData_wb = wb_data_q;
    rdAddr_wb       = wb_rd_q;
    RegWrite_wb     = wb_we_q;
    bus_err         = bus_err_q;
  end

  // EX/MEM register: advance when not stalled; an empty EX slot becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem_q    <= 1'b0;
      alu_mem_q      <= '0;
      wdata_mem_q    <= '0;
      rd_mem_q       <= '0;
      regwrite_mem_q <= 1'b0;
      memread_mem_q  <= 1'b0;
      memwrite_mem_q <= 1'b0;
      memtoreg_mem_q <= 1'b0;
    end else if (!stall_mem) begin
      valid_mem_q    <= valid_ex;
      alu_mem_q      <= ALUResult_ex;
      wdata_mem_q    <= MemWriteData_ex;
      rd_mem_q       <= rdAddr_ex;
      regwrite_mem_q <= valid_ex & RegWrite_ex;
      memread_mem_q  <= valid_ex & MemRead_ex;
      memwrite_mem_q <= valid_ex & MemWrite_ex;
      memtoreg_mem_q <= valid_ex & MemtoReg_ex;
    end
  end

  // Access sequencer: next state and saturating wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (memop && !dmem_ack) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + TCNT_W'(1);
        if (!memop || dmem_ack) begin
          // Defensive exit on !memop; the stall keeps the access in place normally.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q >= TimeoutLast) begin
          state_d = StAbort;
          cnt_d   = '0;
        end
      end
      StAbort: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-back selection. An aborted access retires without a register write,
  // and a store never writes the register file.
  always_comb begin
    wb_data_d = (memtoreg_mem_q && !in_abort) ? dmem_rdata : alu_mem_q;
    wb_we_d   = regwrite_mem_q & ~memwrite_mem_q & ~in_abort;
  end

  // MEM/WB register: holds while stalled so the WB forwarding source stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
    end else if (!stall_mem) begin
      wb_data_q <= wb_data_d;
      wb_rd_q   <= rd_mem_q;
      wb_we_q   <= wb_we_d;
    end
  end

  // Sticky bus error: set by any aborted access, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else if (in_abort && memop) begin
      bus_err_q <= 1'b1;
    end
  end

`ifdef MEM_PERF_CNT_EN
  logic access_end;

  assign access_end = memop & (dmem_ack | in_abort);

  // Performance counters: stall cycles and finished (completed or aborted) accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      mem_ops      <= '0;
    end else begin
      if (stall_mem) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (access_end) begin
        mem_ops <= mem_ops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by random
// instruction streams, compared every cycle against a transaction-level model
// in which each memory access has a known ack latency.
module tb_mem_wb_stage;

  localparam int TO = 4;

  typedef struct {
    bit          v;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    bit          rw;
    bit          mr;
    bit          mw;
    bit          m2r;
    int          lat;   // cycles until ack; above TO means the access times out
    logic [31:0] rdat;  // data the memory returns with the ack
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex;
  logic [31:0] ALUResult_ex;
  logic [31:0] MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex;
  logic        MemRead_ex;
  logic        MemWrite_ex;
  logic        MemtoReg_ex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        MemRead_mem;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic        bus_err;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] mem_ops;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(
    .ACK_TIMEOUT(TO),
    .TCNT_W     (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_ex       (valid_ex),
    .ALUResult_ex   (ALUResult_ex),
    .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex      (rdAddr_ex),
    .RegWrite_ex    (RegWrite_ex),
    .MemRead_ex     (MemRead_ex),
    .MemWrite_ex    (MemWrite_ex),
    .MemtoReg_ex    (MemtoReg_ex),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stall_mem      (stall_mem),
    .MemRead_mem    (MemRead_mem),
    .ALUResult_mem  (ALUResult_mem),
    .rdAddr_mem     (rdAddr_mem),
    .RegWrite_mem   (RegWrite_mem),
    .RegWriteData_wb(RegWriteData_wb),
    .rdAddr_wb      (rdAddr_wb),
    .RegWrite_wb    (RegWrite_wb),
    .bus_err        (bus_err)
`ifdef MEM_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .mem_ops        (mem_ops)
`endif
  );

  // Reference model state
  ins_t        ex_m;
  ins_t        mem_m;
  int          age;        // cycles the MEM occupant has spent in MEM
  bit          wb_chk;     // WB data/rd are defined (valid, non-aborted retire)
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  bit          wb_we;
  bit          berr;
  int unsigned perf_stall;
  int unsigned perf_ops;
  bit          advanced;
  int          stall_seen;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input bit v, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                              input bit m2r, input int lat, input logic [31:0] rdat);
    ins_t i;
    i.v = v; i.alu = alu; i.wd = wd; i.rd = rd; i.rw = rw;
    i.mr = mr; i.mw = mw; i.m2r = m2r; i.lat = lat; i.rdat = rdat;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
  endfunction

  function automatic int pick_lat();
    int p;
    p = int'($urandom_range(0, 9));
    if (p < 5) return 0;
    if (p < 8) return int'($urandom_range(1, 3));
    if (p == 8) return TO;
    return int'($urandom_range(TO + 1, TO + 2));
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int   k;
    k = int'($urandom_range(0, 9));
    i = mk(1'b1, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 1'b0,
           pick_lat(), $urandom);
    if (k < 2) begin
      i.v = 1'b0; i.rw = 1'($urandom); i.mr = 1'($urandom);  // bubble with junk controls
    end else if (k < 5) begin
      i.rw = 1'($urandom);
    end else if (k < 8) begin
      i.mr = 1'b1; i.m2r = 1'b1;
    end else begin
      i.mw = 1'b1; i.rw = 1'($urandom);
    end
    return i;
  endfunction

  // One clock: drive EX and the memory responder, check at negedge, advance model.
  task automatic tick();
    bit memop, ack, abrt, stall;
    memop = mem_m.v && (mem_m.mr || mem_m.mw);
    ack   = memop && mem_m.lat <= TO && age == mem_m.lat;
    abrt  = memop && mem_m.lat > TO && age == TO + 1;
    stall = memop && !ack && !abrt;

    valid_ex        = ex_m.v;
    ALUResult_ex    = ex_m.alu;
    MemWriteData_ex = ex_m.wd;
    rdAddr_ex       = ex_m.rd;
    RegWrite_ex     = ex_m.rw;
    MemRead_ex      = ex_m.mr;
    MemWrite_ex     = ex_m.mw;
    MemtoReg_ex     = ex_m.m2r;
    dmem_ack        = ack;
    dmem_rdata      = ack ? mem_m.rdat : $urandom;

    @(negedge clk);
    if (stall_mem) stall_seen++;
    chk("dmem_req", dmem_req, memop && !abrt);
    chk("stall_mem", stall_mem, stall);
    chk("dmem_we", dmem_we, mem_m.v && mem_m.mw);
    chk("MemRead_mem", MemRead_mem, mem_m.v && mem_m.mr);
    chk("RegWrite_mem", RegWrite_mem, mem_m.v && mem_m.rw);
    if (mem_m.v) begin
      chk("ALUResult_mem", ALUResult_mem, mem_m.alu);
      chk("dmem_addr", dmem_addr, mem_m.alu);
      chk("dmem_wdata", dmem_wdata, mem_m.wd);
      chk("rdAddr_mem", rdAddr_mem, mem_m.rd);
    end
    chk("RegWrite_wb", RegWrite_wb, wb_we);
    if (wb_chk) begin
      chk("RegWriteData_wb", RegWriteData_wb, wb_data);
      chk("rdAddr_wb", rdAddr_wb, wb_rd);
    end
    chk("bus_err", bus_err, berr);
`ifdef MEM_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, perf_stall);
    chk("mem_ops", mem_ops, perf_ops);
`endif

    @(posedge clk);
    #1;
    if (stall) begin
      age++;
      perf_stall++;
    end else begin
      wb_we   = mem_m.v && mem_m.rw && !mem_m.mw && !abrt;
      wb_rd   = mem_m.rd;
      wb_data = mem_m.m2r ? mem_m.rdat : mem_m.alu;
      wb_chk  = mem_m.v && !abrt;
      if (abrt) berr = 1'b1;
      if (abrt || ack) perf_ops++;
      mem_m = ex_m;
      if (!mem_m.v) begin
        mem_m.rw = 1'b0; mem_m.mr = 1'b0; mem_m.mw = 1'b0; mem_m.m2r = 1'b0;
      end
      age = 0;
    end
    advanced = !stall;
  endtask

  // Present an instruction in EX and clock until the stage accepts it.
  task automatic send(input ins_t i);
    ex_m = i;
    for (int n = 0; n < TO + 4; n++) begin
      tick();
      if (advanced) return;
    end
    tests++;
    fails++;
    $error("FAIL send_accept: observed stalled for %0d cycles required acceptance", TO + 4);
  endtask

  task automatic reset_model();
    ex_m = bubble(); mem_m = bubble(); age = 0;
    wb_chk = 1'b1; wb_data = 32'h0; wb_rd = 5'd0; wb_we = 1'b0;
    berr = 1'b0; perf_stall = 0; perf_ops = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_dmem_req"}, dmem_req, 1'b0);
    chk({pfx, "_dmem_we"}, dmem_we, 1'b0);
    chk({pfx, "_dmem_addr"}, dmem_addr, 32'h0);
    chk({pfx, "_dmem_wdata"}, dmem_wdata, 32'h0);
    chk({pfx, "_stall_mem"}, stall_mem, 1'b0);
    chk({pfx, "_MemRead_mem"}, MemRead_mem, 1'b0);
    chk({pfx, "_ALUResult_mem"}, ALUResult_mem, 32'h0);
    chk({pfx, "_rdAddr_mem"}, rdAddr_mem, 5'd0);
    chk({pfx, "_RegWrite_mem"}, RegWrite_mem, 1'b0);
    chk({pfx, "_RegWriteData_wb"}, RegWriteData_wb, 32'h0);
    chk({pfx, "_rdAddr_wb"}, rdAddr_wb, 5'd0);
    chk({pfx, "_RegWrite_wb"}, RegWrite_wb, 1'b0);
    chk({pfx, "_bus_err"}, bus_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    reset_model();
    valid_ex = 1'b0; ALUResult_ex = '0; MemWriteData_ex = '0; rdAddr_ex = '0;
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0; MemWrite_ex = 1'b0; MemtoReg_ex = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    stall_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU op forwarded from MEM, then written back.
    send(mk(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    chk("alu_mem_fwd", ALUResult_mem, 32'h10);
    send(bubble());
    chk("alu_wb_data", RegWriteData_wb, 32'h10);
    chk("alu_wb_rd", rdAddr_wb, 5'd5);
    chk("alu_wb_we", RegWrite_wb, 1'b1);

    // Zero-wait load.
    send(mk(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'hDEADBEEF));
    stall_seen = 0;
    send(bubble());
    chk("load0_stalls", stall_seen, 0);
    chk("load0_wb_data", RegWriteData_wb, 32'hDEADBEEF);

    // Store acked after three wait cycles.
    send(mk(1'b1, 32'h200, 32'h55, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 3, 32'h0));
    stall_seen = 0;
    send(mk(1'b1, 32'h33, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0));
    chk("store_stalls", stall_seen, 3);
    chk("store_no_wb", RegWrite_wb, 1'b0);
`ifdef MEM_PERF_CNT_EN
    chk("perf_stall_cycles", stall_cycles, 32'd3);
    chk("perf_mem_ops", mem_ops, 32'd2);
`endif

    // Load that never gets an ack: times out and aborts.
    send(mk(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 99, 32'h0));
    stall_seen = 0;
    send(bubble());
    chk("timeout_stalls", stall_seen, TO + 1);
    chk("timeout_no_wb", RegWrite_wb, 1'b0);
    chk("timeout_bus_err", bus_err, 1'b1);

    // Reset while an access is waiting for its ack.
    send(mk(1'b1, 32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3, 32'h1234));
    ex_m = bubble();
    tick();
    chk("wait_req_before_rst", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      send(rand_ins());
    end
    for (int n = 0; n < 3; n++) begin
      send(bubble());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Producer end of the EX-stage forwarding interface.
- Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory access over a req/ack handshake.
- Selects the write-back data and drives the six forwarding signals the EX stage consumes: ALUResult_mem, rdAddr_mem, RegWrite_mem, RegWriteData_wb, rdAddr_wb, RegWrite_wb.
- Generates the memory stall that freezes the IF through EX stages.

Parameters:
ACK_TIMEOUT, 16, wait cycles allowed for dmem_ack before the access is aborted (range 1..255)
TCNT_W, 8, width of the wait counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_ex  input  1  an instruction is present in EX
ALUResult_ex  input  32  ALU result or address from EX
MemWriteData_ex  input  32  store data, already forwarded
rdAddr_ex  input  5  destination register
RegWrite_ex  input  1  instruction writes the register file
MemRead_ex  input  1  load
MemWrite_ex  input  1  store
MemtoReg_ex  input  1  write-back takes load data
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  32  byte address (ALUResult_mem)
dmem_wdata  output  32  store data
dmem_ack  input  1  request accepted and completed this cycle
dmem_rdata  input  32  read data, valid when dmem_ack=1
stall_mem  output  1  freeze IF, ID and EX
MemRead_mem  output  1  load in MEM, for the load-use hazard unit
ALUResult_mem  output  32  forwarding source from MEM
rdAddr_mem  output  5  forwarding source from MEM
RegWrite_mem  output  1  forwarding source from MEM
RegWriteData_wb  output  32  register-file write data and forwarding source
rdAddr_wb  output  5  register-file write address
RegWrite_wb  output  1  register-file write enable
bus_err  output  1  sticky flag: an access timed out

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all pipeline registers and outputs are 0, FSM is IDLE, wait counter is 0, bus_err is 0. Reset asserted mid-access drops dmem_req immediately; the pending access is abandoned.
- EX/MEM register:
  - Loads all _ex inputs on each edge when stall_mem=0.
  - Holds while stall_mem=1.
  - valid_ex=0 loads a bubble: all control bits 0.
- Memory operation: memop = valid_mem & (MemRead_mem | MemWrite_mem).
- FSM states:
  - IDLE: memop=1 and dmem_ack=0 -> WAIT. memop=1 and dmem_ack=1 -> complete in the same cycle (zero-wait memory).
  - WAIT: dmem_ack=1 -> IDLE. Counter reaches ACK_TIMEOUT -> ABORT.
  - ABORT: lasts one cycle, then IDLE.
- Request: dmem_req = memop & state!=ABORT & !done. dmem_addr, dmem_we and dmem_wdata stay stable from request until ack (req/ack rule).
- Stall: stall_mem = memop & !dmem_ack & state!=ABORT. Zero-wait access gives no stall; an N-cycle ack gives N stall cycles.
- Wait counter: cleared in IDLE, +1 per WAIT cycle, saturates, never wraps.
- MEM/WB register:
  - Loads when stall_mem=0.
  - RegWriteData_wb = MemtoReg ? captured dmem_rdata : ALUResult_mem.
  - While stalled, MEM/WB holds its contents (no bubble), so the EX-stage forwarding source stays valid. Rewriting the same register value is idempotent.
- Abort: the instruction retires with RegWrite_wb=0 and bus_err is set to 1. bus_err clears only on reset.
- Stores never assert RegWrite_wb.
- rd=x0: passed through unchanged; x0 suppression is the consumer's job.
- MemRead_mem = valid_mem & MemRead. The hazard unit uses it for the one-cycle load-use stall.

Optional Feature:
MEM_PERF_CNT_EN:
- Defined: adds 32-bit outputs stall_cycles and mem_ops. stall_cycles +1 per cycle with stall_mem=1. mem_ops +1 per completed or aborted access. Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- ALU op (ALUResult_ex=0x10, rd=5, RegWrite=1) -> next cycle ALUResult_mem=0x10, RegWrite_mem=1; cycle after, RegWriteData_wb=0x10, rdAddr_wb=5, RegWrite_wb=1; stall_mem stays 0.
- Load addr 0x100, ack same cycle with rdata 0xDEADBEEF -> no stall; RegWriteData_wb=0xDEADBEEF next cycle.
- Store addr 0x200, wdata 0x55, ack after 3 cycles -> dmem_req/addr/wdata stable for 4 cycles; stall_mem=1 for exactly 3 cycles; MEM/WB and EX/MEM held; RegWrite_wb=0.
- Load with no ack, ACK_TIMEOUT=4 -> req high for 4 wait cycles, one ABORT cycle, then bus_err=1, RegWrite_wb=0, pipeline resumes.
- rst_n low during WAIT -> dmem_req=0 with no clock edge; all outputs 0; FSM IDLE after release.
- With MEM_PERF_CNT_EN: the two scenarios above -> stall_cycles=3, mem_ops=2.
